// File: rtl/universal_ff_bank.sv
// Bank of WIDTH independent flip-flops selectable as SR/JK/D/T, with a sticky SR-illegal flag.
// Define UFF_ILLEGAL_CNT_EN to build the saturating illegal-event counter; otherwise illegal_cnt is tied to 0.
module universal_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               SR_ILL  = 0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             illegal,
    input  logic             illegal_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q;
    logic             illegal_q, illegal_d;
    logic             illegal_evt;

    function automatic logic next_bit(input logic [1:0] m, input logic qc,
                                      input logic x, input logic y);
        logic nb;
        nb = qc;
        case (m)
            MODE_SR: begin
                case ({x, y})
                    2'b01:   nb = 1'b0;
                    2'b10:   nb = 1'b1;
                    2'b11: begin
                        // SR_ILL=3 deliberately falls through to hold
                        case (SR_ILL)
                            1:       nb = 1'b0;
                            2:       nb = 1'b1;
                            default: nb = qc;
                        endcase
                    end
                    default: nb = qc;
                endcase
            end
            MODE_JK: begin
                case ({x, y})
                    2'b01:   nb = 1'b0;
                    2'b10:   nb = 1'b1;
                    2'b11:   nb = ~qc;
                    default: nb = qc;
                endcase
            end
            MODE_D:  nb = x;
            MODE_T:  nb = x ? ~qc : qc;
            default: nb = qc;
        endcase
        return nb;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            assign q_d[gi] = next_bit(mode, q_q[gi], a[gi], b[gi]);
        end
    endgenerate

    // One event per cycle no matter how many channels see s=r=1
    assign illegal_evt = en && (mode == MODE_SR) && (|(a & b));

    always_comb begin
        illegal_d = illegal_q;
        if (illegal_evt)
            illegal_d = 1'b1;
        else if (illegal_clr)
            illegal_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= RST_VAL;
            qb_q      <= ~RST_VAL;
            illegal_q <= 1'b0;
        end else begin
            if (en) begin
                q_q  <= q_d;
                qb_q <= ~q_d;
            end
            illegal_q <= illegal_d;
        end
    end

`ifdef UFF_ILLEGAL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A clear coinciding with an event restarts the count at one
    always_comb begin
        cnt_d = cnt_q;
        if (illegal_clr)
            cnt_d = illegal_evt ? CNT_W'(1) : '0;
        else if (illegal_evt && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign illegal_cnt = cnt_q;
`else
    assign illegal_cnt = '0;
`endif

    assign q       = q_q;
    assign qb      = qb_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Directed bench for universal_ff_bank (WIDTH=8, RST_VAL=0, SR_ILL=0, CNT_W=4).
// Counter expectations follow UFF_ILLEGAL_CNT_EN; without it illegal_cnt must stay 0.
module tb_universal_ff_bank;

`ifdef UFF_ILLEGAL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] qb;
    logic       illegal;
    logic       illegal_clr;
    logic [3:0] illegal_cnt;

    int checks   = 0;
    int failures = 0;

    universal_ff_bank #(
        .WIDTH  (8),
        .RST_VAL(8'h00),
        .SR_ILL (0),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .en         (en),
        .a          (a),
        .b          (b),
        .q          (q),
        .qb         (qb),
        .illegal    (illegal),
        .illegal_clr(illegal_clr),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b1; mode = 2'b10; a = 8'h00; b = 8'h00; illegal_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q: got %h want %h", q, 8'h00); end
        checks++; if (qb !== 8'hFF) begin failures++; $display("FAIL reset_qb: got %h want %h", qb, 8'hFF); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (illegal_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", illegal_cnt); end
        step();
        step();
        rst_n = 1'b1;
        $display("test_reset: q=%h qb=%h illegal=%b cnt=%0d", q, qb, illegal, illegal_cnt);
    endtask

    task automatic test_d();
        mode = 2'b10; a = 8'hA5;
        step();
        checks++; if (q !== 8'hA5) begin failures++; $display("FAIL d_q: got %h want %h", q, 8'hA5); end
        checks++; if (qb !== 8'h5A) begin failures++; $display("FAIL d_qb: got %h want %h", qb, 8'h5A); end
        $display("test_d: a=%h q=%h qb=%h", a, q, qb);
    endtask

    task automatic test_t();
        mode = 2'b11; a = 8'h0F;
        step();
        checks++; if (q !== 8'hAA) begin failures++; $display("FAIL t_q1: got %h want %h", q, 8'hAA); end
        step();
        checks++; if (q !== 8'hA5) begin failures++; $display("FAIL t_q2: got %h want %h", q, 8'hA5); end
        checks++; if (qb !== 8'h5A) begin failures++; $display("FAIL t_qb2: got %h want %h", qb, 8'h5A); end
        $display("test_t: a=%h q=%h", a, q);
    endtask

    task automatic test_jk();
        mode = 2'b10; a = 8'hF0;
        step();
        checks++; if (q !== 8'hF0) begin failures++; $display("FAIL jk_load: got %h want %h", q, 8'hF0); end
        mode = 2'b01; a = 8'hFF; b = 8'hFF;
        step();
        checks++; if (q !== 8'h0F) begin failures++; $display("FAIL jk_toggle: got %h want %h", q, 8'h0F); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL jk_illegal: got %b want 0", illegal); end
        a = 8'h3C; b = 8'hC3;
        step();
        checks++; if (q !== 8'h3C) begin failures++; $display("FAIL jk_setreset: got %h want %h", q, 8'h3C); end
        checks++; if (qb !== 8'hC3) begin failures++; $display("FAIL jk_qb: got %h want %h", qb, 8'hC3); end
        $display("test_jk: q=%h illegal=%b", q, illegal);
    endtask

    task automatic test_sr_illegal();
        mode = 2'b00; a = 8'h81; b = 8'h01;
        step();
        checks++; if (q !== 8'hBC) begin failures++; $display("FAIL sr_q: got %h want %h", q, 8'hBC); end
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL sr_illegal: got %b want 1", illegal); end
        checks++; if (illegal_cnt !== (CNT_ON ? 4'd1 : 4'd0)) begin failures++; $display("FAIL sr_cnt1: got %0d want %0d", illegal_cnt, CNT_ON ? 4'd1 : 4'd0); end
        for (int i = 0; i < 19; i++) step();
        checks++; if (illegal_cnt !== (CNT_ON ? 4'd15 : 4'd0)) begin failures++; $display("FAIL sr_cnt_sat: got %0d want %0d", illegal_cnt, CNT_ON ? 4'd15 : 4'd0); end
        checks++; if (q !== 8'hBC) begin failures++; $display("FAIL sr_hold: got %h want %h", q, 8'hBC); end
        a = 8'h00; b = 8'h0C;
        step();
        checks++; if (q !== 8'hB0) begin failures++; $display("FAIL sr_reset_bits: got %h want %h", q, 8'hB0); end
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL sr_sticky: got %b want 1", illegal); end
        b = 8'h00; illegal_clr = 1'b1;
        step();
        illegal_clr = 1'b0;
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL sr_clr_flag: got %b want 0", illegal); end
        checks++; if (illegal_cnt !== 4'd0) begin failures++; $display("FAIL sr_clr_cnt: got %0d want 0", illegal_cnt); end
        $display("test_sr_illegal: q=%h illegal=%b cnt=%0d", q, illegal, illegal_cnt);
    endtask

    task automatic test_same_edge_clr();
        mode = 2'b00; a = 8'h01; b = 8'h01;
        step();
        step();
        checks++; if (illegal_cnt !== (CNT_ON ? 4'd2 : 4'd0)) begin failures++; $display("FAIL se_cnt2: got %0d want %0d", illegal_cnt, CNT_ON ? 4'd2 : 4'd0); end
        illegal_clr = 1'b1;
        step();
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL se_flag: got %b want 1", illegal); end
        checks++; if (illegal_cnt !== (CNT_ON ? 4'd1 : 4'd0)) begin failures++; $display("FAIL se_cnt: got %0d want %0d", illegal_cnt, CNT_ON ? 4'd1 : 4'd0); end
        checks++; if (q !== 8'hB0) begin failures++; $display("FAIL se_q: got %h want %h", q, 8'hB0); end
        a = 8'h00; b = 8'h00;
        step();
        illegal_clr = 1'b0;
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL se_clr_after: got %b want 0", illegal); end
        $display("test_same_edge_clr: illegal=%b cnt=%0d", illegal, illegal_cnt);
    endtask

    task automatic test_enable_low();
        en = 1'b0; mode = 2'b10; a = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (q !== 8'hB0) begin failures++; $display("FAIL en_hold_%0d: got %h want %h", i, q, 8'hB0); end
        end
        checks++; if (qb !== 8'h4F) begin failures++; $display("FAIL en_qb: got %h want %h", qb, 8'h4F); end
        mode = 2'b00; b = 8'hFF;
        step();
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL en_no_event: got %b want 0", illegal); end
        checks++; if (illegal_cnt !== 4'd0) begin failures++; $display("FAIL en_cnt: got %0d want 0", illegal_cnt); end
        en = 1'b1; a = 8'h01; b = 8'h01;
        step();
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL en_event: got %b want 1", illegal); end
        en = 1'b0; illegal_clr = 1'b1;
        step();
        illegal_clr = 1'b0;
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL en_clr_flag: got %b want 0", illegal); end
        checks++; if (illegal_cnt !== 4'd0) begin failures++; $display("FAIL en_clr_cnt: got %0d want 0", illegal_cnt); end
        en = 1'b1; a = 8'h00; b = 8'h00;
        $display("test_enable_low: q=%h illegal=%b cnt=%0d", q, illegal, illegal_cnt);
    endtask

    task automatic test_reset_midop();
        mode = 2'b00; a = 8'h01; b = 8'h01;
        step();
        mode = 2'b10; a = 8'hFF; illegal_clr = 1'b0; en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL mid_q: got %h want %h", q, 8'h00); end
        checks++; if (qb !== 8'hFF) begin failures++; $display("FAIL mid_qb: got %h want %h", qb, 8'hFF); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL mid_illegal: got %b want 0", illegal); end
        step();
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL mid_hold: got %h want %h", q, 8'h00); end
        rst_n = 1'b1; a = 8'h5A;
        step();
        checks++; if (q !== 8'h5A) begin failures++; $display("FAIL post_reset_q: got %h want %h", q, 8'h5A); end
        checks++; if (qb !== 8'hA5) begin failures++; $display("FAIL post_reset_qb: got %h want %h", qb, 8'hA5); end
        $display("test_reset_midop: q=%h qb=%h", q, qb);
    endtask

    initial begin
        test_reset();
        test_d();
        test_t();
        test_jk();
        test_sr_illegal();
        test_same_edge_clr();
        test_enable_low();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_ff_bank.md
UNIVERSAL_FF_BANK -- requirements
Module: universal_ff_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent flip-flop channels.
REQ-002 Parameter RST_VAL, default 0 (WIDTH bits): q value loaded on reset.
REQ-003 Parameter SR_ILL, default 0: SR-mode policy for s=r=1.
- 0 = hold.
- 1 = force q=0.
- 2 = force q=1.
- 3 = treated as 0.
REQ-004 Parameter CNT_W, default 8: width of the illegal-event counter.
REQ-005 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port mode, input, 2: channel behaviour.
- 00 = SR.
- 01 = JK.
- 10 = D.
- 11 = T.
REQ-008 Port en, input, 1: clock enable; 0 holds all state.
REQ-009 Port a, input, WIDTH: per-channel S (SR), J (JK), D (D) or T (T).
REQ-010 Port b, input, WIDTH: per-channel R (SR) or K (JK); ignored in D and T modes.
REQ-011 Port q, output, WIDTH: registered true outputs.
REQ-012 Port qb, output, WIDTH: registered complement outputs.
REQ-013 Port illegal, output, 1: sticky flag, set by any SR-mode s=r=1 event.
REQ-014 Port illegal_clr, input, 1: synchronous clear of illegal and illegal_cnt.
REQ-015 Port illegal_cnt, output, CNT_W: saturating count of illegal cycles (see Configuration).

Function
REQ-016 On a posedge with en=1, each channel i SHALL compute next q[i] from the current mode:
- SR: 00 hold, 01 q=0, 10 q=1, 11 per SR_ILL.
- JK: 00 hold, 01 q=0, 10 q=1, 11 toggle.
- D: q=a[i].
- T: a[i]=1 toggles, a[i]=0 holds.
REQ-017 With en=0, q, qb, illegal and illegal_cnt SHALL hold; illegal_clr still acts.
REQ-018 Latency SHALL be one cycle: inputs sampled at edge k appear on q at edge k.
REQ-019 qb SHALL equal ~q at every cycle, including during and after reset; no X is ever driven.
REQ-020 mode is sampled every edge with no internal mode state; a mode change takes effect on the same edge, with no transition cycle.
REQ-021 An illegal event is a cycle with en=1, mode=00 and (a & b) nonzero; it SHALL count once per cycle regardless of how many channels are affected.
REQ-022 An illegal event SHALL set illegal on that edge.
REQ-023 illegal_clr=1 SHALL clear illegal and illegal_cnt on the edge.
REQ-024 If illegal_clr and an illegal event occur on the same edge, the result SHALL be illegal=1 and illegal_cnt=1.
REQ-025 illegal_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 JK/SR forms with a=b=1 in JK mode are legal and SHALL NOT flag.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force q=RST_VAL, qb=~RST_VAL, illegal=0 and illegal_cnt=0.
REQ-028 Reset asserted mid-operation SHALL override en, illegal_clr and all data inputs.
REQ-029 The first edge after rst_n rises SHALL perform a normal update.

Configuration
REQ-030 Macro UFF_ILLEGAL_CNT_EN: when defined, illegal_cnt SHALL be implemented per REQ-023 to REQ-025.
REQ-031 When UFF_ILLEGAL_CNT_EN is undefined, the port SHALL remain and be tied to 0, and no counter logic SHALL be synthesised; the illegal flag is unaffected.

Verification (WIDTH=8, RST_VAL=8'h00, SR_ILL=0, CNT_W=4, macro defined)
REQ-032 Reset check: rst_n=0 between edges -> q=00, qb=FF, illegal=0, cnt=0 asserted before the next clk edge.
REQ-033 Basic modes:
- D mode, a=A5 -> q=A5, qb=5A after 1 edge.
- T mode, a=0F, 2 edges -> q=AA then A5.
REQ-034 JK mode: q=F0, a=FF, b=FF -> q=0F; illegal stays 0.
REQ-035 SR illegal with clear:
- SR mode, a=81, b=01 -> q bit0 held, bit7=1, illegal=1, cnt=1.
- Repeat 20 cycles -> cnt=15, saturated.
- illegal_clr with a legal input -> cnt=0, illegal=0.
REQ-036 Same-edge clear: illegal_clr=1 with an illegal event on the same edge -> illegal=1, cnt=1.
REQ-037 Enable low: en=0 for 3 edges with D mode, a=FF -> q unchanged; recompile without the macro -> cnt constant 0.
